// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the memory-stage access engine
// and a single-port, variable-latency data memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access engine: takes one load/store from EX/MEM, runs it on a
// variable-latency memory, stalls the pipeline meanwhile and flags errors.
module mem_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_rd,
  input  logic                  ex_wr,
  input  logic                  ex_valid,
  input  logic [ADDR_W-1:0]     ex_addr,
  input  logic [DATA_W-1:0]     ex_wdata,
  mem_access_unit_if.master     mem,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        cnt_r;
  logic [7:0]        cnt_s;
  logic              err_r;
  logic              err_next_s;
  logic              mem_en_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;

  logic              req_s;
  logic              illegal_s;
  logic              accept_s;
  logic              load_rdata_s;

  assign req_s     = ex_valid & (ex_rd | ex_wr);
  // Both directions at once, or an odd byte address, is rejected without a bus cycle.
  assign illegal_s = (ex_rd & ex_wr) | ex_addr[0];

  // Next-state, pipeline handshake and retire outputs.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    err_next_s   = err_r;
    accept_s     = 1'b0;
    load_rdata_s = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (illegal_s) begin
            done = 1'b1;
            err  = 1'b1;
          end else begin
            accept_s = 1'b1;
            stall    = 1'b1;
            state_s  = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        stall   = 1'b1;
        cnt_s   = 8'd0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          // An ack on the final allowed cycle still counts as success.
          if (!we_r) begin
            load_rdata_s = 1'b1;
          end else begin
            load_rdata_s = 1'b0;
          end
          err_next_s = 1'b0;
          state_s    = ST_DONE;
        end else if (cnt_r == TO_LAST) begin
          err_next_s = 1'b1;
          state_s    = ST_DONE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_r;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, timeout counter and retire status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 8'd0;
      err_r    <= 1'b0;
      mem_en_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      err_r    <= err_next_s;
      mem_en_r <= accept_s;
    end
  end

  // Request latches: captured on accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      wdata_r <= '0;
      we_r    <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= ex_addr;
      wdata_r <= ex_wdata;
      we_r    <= ex_wr;
    end
  end

  // Load data register: updated only by a successful load ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (load_rdata_s) begin
      rdata_r <= mem.mem_rdata;
    end
  end

  assign mem.mem_en    = mem_en_r;
  assign mem.mem_wr    = we_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;
  assign rdata         = rdata_r;

endmodule
